// File: rtl/huffman_if.sv
// huffman_if: symbol-in valid/ready handshake plus serial code-bit output of the encoder
interface huffman_if #(parameter int FIFO_DEPTH = 4);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [2:0] sym_in;
  logic sym_valid;
  logic sym_ready;
  logic out;
  logic out_valid;
  logic sym_start;
  logic err_sym;
  logic [CW-1:0] fifo_count;
  modport master (
    output sym_in, sym_valid,
    input sym_ready, out, out_valid, sym_start, err_sym, fifo_count
  );
  modport slave (
    input sym_in, sym_valid,
    output sym_ready, out, out_valid, sym_start, err_sym, fifo_count
  );
endinterface

// File: rtl/huffman_encoder.sv
// huffman_encoder: buffers symbols 1..6 in a FIFO and serializes their prefix codes MSB-first
module huffman_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  huffman_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, SHIFT} state_e;
  state_e state_q, state_d;
  logic [2:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [5:0] sh_q, sh_d;
  logic [2:0] len_q, len_d;
  logic start_q, start_d, err_q;
  logic xfer, legal, push, pop;
  logic [2:0] head;
  assign bus.sym_ready = !rst && (count_q < CW'(FIFO_DEPTH));
  assign xfer = bus.sym_valid && bus.sym_ready;
  assign legal = (bus.sym_in != 3'd0) && (bus.sym_in != 3'd7);
  assign push = xfer && legal;
  assign head = mem_q[rptr_q];
  // Reload on the last bit of a codeword keeps back-to-back codes gap-free
  assign pop = (count_q != '0) && (state_q == IDLE || len_q == 3'd1);
  assign count_d = count_q + CW'(push) - CW'(pop);
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    len_d = len_q;
    start_d = 1'b0;
    if (pop) begin
      state_d = SHIFT;
      start_d = 1'b1;
      sh_d = head == 3'd1 ? 6'b000000 :
             head == 3'd2 ? 6'b010000 :
             head == 3'd3 ? 6'b100000 :
             head == 3'd4 ? 6'b110000 :
             head == 3'd5 ? 6'b111000 : 6'b111001;
      len_d = head <= 3'd3 ? 3'd2 : head == 3'd4 ? 3'd3 : 3'd6;
    end else if (state_q == SHIFT) begin
      sh_d = {sh_q[4:0], 1'b0};
      len_d = len_q - 3'd1;
      state_d = len_q == 3'd1 ? IDLE : SHIFT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      len_q <= '0;
      start_q <= 1'b0;
      err_q <= 1'b0;
      count_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      len_q <= len_d;
      start_q <= start_d;
      err_q <= xfer && !legal;
      count_q <= count_d;
      wptr_q <= wptr_q + AW'(push);
      rptr_q <= rptr_q + AW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.sym_in;
  end
  assign bus.out = (state_q == SHIFT) && sh_q[5];
  assign bus.out_valid = state_q == SHIFT;
  assign bus.sym_start = start_q;
  assign bus.err_sym = err_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_huffman_encoder.sv
// tb_huffman_encoder: directed and random checks of the encoder against a prefix-code model
module tb_huffman_encoder;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  huffman_if #(.FIFO_DEPTH(D)) bus ();
  huffman_encoder #(.FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_pulses = 0;
  int max_cnt = 0;
  bit bits[$];
  bit starts[$];
  int stamps[$];
  int sent[$];
  int dec[$];
  int code_v[7] = '{0, 0, 1, 2, 6, 56, 57};
  int code_l[7] = '{0, 2, 2, 2, 3, 6, 6};
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.err_sym === 1'b1) err_pulses++;
    if (!rst) begin
      if (bus.out_valid) begin
        bits.push_back(bus.out);
        starts.push_back(bus.sym_start);
        stamps.push_back(cyc);
      end
      if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
      checks++;
      if (bus.sym_ready !== (int'(bus.fifo_count) < D)) begin
        errors++;
        $display("FAIL ready_vs_count: ready=%b count=%0d", bus.sym_ready, bus.fifo_count);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic clear();
    bits.delete();
    starts.delete();
    stamps.delete();
    sent.delete();
    dec.delete();
    max_cnt = 0;
    err_pulses = 0;
  endtask
  task automatic send(input logic [2:0] s);
    int n = 0;
    bus.sym_valid = 1'b1;
    bus.sym_in = s;
    @(negedge clk);
    while (!bus.sym_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL send_timeout: sym=%0d not accepted within 50 cycles", s);
    end
    sent.push_back(int'(s));
    @(posedge clk);
    #1 bus.sym_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((bus.fifo_count != 0 || bus.out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: count=%0d out_valid=%b", bus.fifo_count, bus.out_valid);
    end
  endtask
  task automatic decode(output int bad);
    int v = 0;
    int n = 0;
    bit hit;
    bad = 0;
    dec.delete();
    for (int i = 0; i < bits.size(); i++) begin
      if (starts[i] != (n == 0)) bad++;
      v = v * 2 + int'(bits[i]);
      n++;
      hit = 1'b0;
      for (int s = 1; s <= 6; s++)
        if (!hit && n == code_l[s] && v == code_v[s]) begin
          dec.push_back(s);
          hit = 1'b1;
        end
      if (hit || n > 6) begin
        if (!hit) bad++;
        v = 0;
        n = 0;
      end
    end
    if (n != 0) bad++;
  endtask
  task automatic test_reset();
    bus.sym_valid = 1'b0;
    bus.sym_in = 3'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.sym_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: got %b want 0", bus.sym_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out, bus.sym_start, bus.err_sym} !== 4'b0 || bus.fifo_count !== '0 || bus.sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: ov=%b out=%b start=%b err=%b count=%0d ready=%b want 0 0 0 0 0 1",
               bus.out_valid, bus.out, bus.sym_start, bus.err_sym, bus.fifo_count, bus.sym_ready);
    end
  endtask
  task automatic test_single();
    @(posedge clk);
    #1 clear();
    send(3'd1);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_c1: ov=%b want 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out, bus.sym_start} !== 3'b101) begin
      errors++;
      $display("FAIL single_c2: ov,out,start=%b want 101", {bus.out_valid, bus.out, bus.sym_start});
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out, bus.sym_start} !== 3'b100) begin
      errors++;
      $display("FAIL single_c3: ov,out,start=%b want 100", {bus.out_valid, bus.out, bus.sym_start});
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_c4: ov=%b want 0", bus.out_valid);
    end
  endtask
  task automatic test_back_to_back();
    logic [11:0] exp = 12'b111000111001;
    int bad;
    @(posedge clk);
    #1 clear();
    send(3'd5);
    send(3'd6);
    drain();
    checks++;
    if (bits.size() != 12) begin
      errors++;
      $display("FAIL b2b_len: got %0d bits want 12", bits.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (bits[i] != exp[11-i] || starts[i] != (i == 0 || i == 6) || stamps[i] != stamps[0] + i) begin
          errors++;
          $display("FAIL b2b_bit%0d: out=%b start=%b cyc=%0d want out=%b start=%b cyc=%0d",
                   i, bits[i], starts[i], stamps[i], exp[11-i], (i == 0 || i == 6), stamps[0] + i);
        end
      end
    end
    decode(bad);
    checks++;
    if (bad != 0 || dec.size() != 2 || dec[0] != 5 || dec[1] != 6) begin
      errors++;
      $display("FAIL b2b_decode: %0d symbols, framing errors %0d, want 5,6", dec.size(), bad);
    end
  endtask
  task automatic test_full();
    int xfers = 0;
    int bad;
    @(posedge clk);
    #1 clear();
    bus.sym_valid = 1'b1;
    bus.sym_in = 3'd6;
    repeat (30) begin
      @(negedge clk);
      if (bus.sym_ready) xfers++;
      if (bus.fifo_count == 3'(D)) begin
        checks++;
        if (bus.sym_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_ready: ready=%b at count %0d want 0", bus.sym_ready, bus.fifo_count);
        end
      end
    end
    @(posedge clk);
    #1 bus.sym_valid = 1'b0;
    drain();
    checks++;
    if (max_cnt != D) begin
      errors++;
      $display("FAIL full_max_count: got %0d want %0d", max_cnt, D);
    end
    decode(bad);
    checks++;
    if (bad != 0 || dec.size() != xfers || bits.size() != 6 * xfers) begin
      errors++;
      $display("FAIL full_lossless: decoded %0d (%0d bits, bad %0d) want %0d symbols", dec.size(), bits.size(), bad, xfers);
    end
    foreach (dec[i]) begin
      checks++;
      if (dec[i] != 6) begin
        errors++;
        $display("FAIL full_sym%0d: got %0d want 6", i, dec[i]);
      end
    end
  endtask
  task automatic test_illegal();
    @(posedge clk);
    #1 clear();
    bus.sym_valid = 1'b1;
    bus.sym_in = 3'd7;
    @(posedge clk);
    #1 bus.sym_in = 3'd3;
    @(negedge clk);
    checks++;
    if (bus.err_sym !== 1'b1 || bus.fifo_count !== '0) begin
      errors++;
      $display("FAIL illegal_pulse: err=%b count=%0d want 1 0", bus.err_sym, bus.fifo_count);
    end
    @(posedge clk);
    #1 bus.sym_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.err_sym !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse_end: err=%b want 0", bus.err_sym);
    end
    drain();
    checks++;
    if (err_pulses != 1 || max_cnt > 1) begin
      errors++;
      $display("FAIL illegal_counts: pulses=%0d max_count=%0d want 1, <=1", err_pulses, max_cnt);
    end
    checks++;
    if (bits.size() != 2 || bits[0] != 1'b1 || bits[1] != 1'b0) begin
      errors++;
      $display("FAIL illegal_stream: %0d bits want exactly 1,0", bits.size());
    end
  endtask
  task automatic test_reset_mid();
    @(posedge clk);
    #1 clear();
    send(3'd5);
    send(3'd1);
    send(3'd2);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.fifo_count !== 3'd2 || bus.sym_ready !== 1'b0 || bits.size() != 1) begin
      errors++;
      $display("FAIL rstmid_pre: ov=%b count=%0d ready=%b bits=%0d want 1 2 0 1",
               bus.out_valid, bus.fifo_count, bus.sym_ready, bits.size());
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.fifo_count !== '0 || bus.sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_post: ov=%b count=%0d ready=%b want 0 0 1", bus.out_valid, bus.fifo_count, bus.sym_ready);
    end
    @(posedge clk);
    #1 clear();
    send(3'd2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out, bus.sym_start} !== 3'b101) begin
      errors++;
      $display("FAIL rstmid_bit1: ov,out,start=%b want 101", {bus.out_valid, bus.out, bus.sym_start});
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out, bus.sym_start} !== 3'b110) begin
      errors++;
      $display("FAIL rstmid_bit2: ov,out,start=%b want 110", {bus.out_valid, bus.out, bus.sym_start});
    end
    drain();
    checks++;
    if (bits.size() != 2) begin
      errors++;
      $display("FAIL rstmid_leftover: got %0d bits want 2", bits.size());
    end
  endtask
  task automatic test_random();
    int bad;
    int miss = 0;
    int g;
    @(posedge clk);
    #1 clear();
    for (int k = 0; k < 1000; k++) begin
      g = int'($urandom_range(0, 3)) - 1;
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
      send(3'($urandom_range(1, 6)));
    end
    drain();
    decode(bad);
    checks++;
    if (bad != 0 || dec.size() != sent.size()) begin
      errors++;
      $display("FAIL random_frame: decoded %0d of %0d, framing errors %0d", dec.size(), sent.size(), bad);
    end else begin
      foreach (sent[i])
        if (dec[i] != sent[i]) begin
          if (miss == 0) $display("FAIL random_sym%0d: got %0d want %0d", i, dec[i], sent[i]);
          miss++;
        end
      checks++;
      if (miss != 0) begin
        errors++;
        $display("FAIL random_order: %0d symbols differ", miss);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
